// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for the EX-stage operand muxes of the 5-stage core.
// Optional stall counter enabled by defining FWD_STALL_CNT_EN.
//
// state    | meaning
// RUN      | normal flow; load-use hazard with ID triggers one stall cycle
// LU_STALL | bubble sits in EX, load in MEM; dependant re-enters EX next cycle
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic              stall,
  output logic              bubble,
  output logic [1:0]        M1Sel,
  output logic [1:0]        M2Sel,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

  state_t state;

  logic              ex_valid, ex_regwrite, ex_memread, ex_rs1_used, ex_rs2_used;
  logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2;
  // memread is only consulted in EX, so MEM/WB carry just what forwarding needs
  logic              mem_valid, mem_regwrite;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_valid, wb_regwrite;
  logic [REG_AW-1:0] wb_rd;

  logic luh;

  always_comb begin
    luh = id_valid & ex_valid & ex_memread & (ex_rd != '0) &
          ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
    stall  = (state == RUN) & luh & ~flush;
    bubble = stall | flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:      if (luh && !flush) state <= LU_STALL;
        LU_STALL: state <= RUN;
        default:  state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_rs1_used  <= 1'b0;
      ex_rs2_used  <= 1'b0;
      ex_rd        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_rd       <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_rd        <= '0;
    end else begin
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_rd        <= mem_rd;
      mem_valid    <= ex_valid;
      mem_regwrite <= ex_regwrite;
      mem_rd       <= ex_rd;
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_rs1_used <= 1'b0;
        ex_rs2_used <= 1'b0;
        ex_rd       <= '0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
      end else begin
        ex_valid    <= id_valid;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
        ex_rs1_used <= id_rs1_used;
        ex_rs2_used <= id_rs2_used;
        ex_rd       <= id_rd;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
      end
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs, input logic used);
    if (used && mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == rs))
      return 2'b10;
    else if (used && wb_valid && wb_regwrite && (wb_rd != '0) && (wb_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    M1Sel = fwd_sel(ex_rs1, ex_rs1_used);
    M2Sel = fwd_sel(ex_rs2, ex_rs2_used);
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomized bench for fwd_hazard_ctrl against an instruction-history reference model.
// Honors FWD_STALL_CNT_EN the same way the design does.
module tb_fwd_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_memread, flush;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              stall, bubble;
  logic [1:0]        M1Sel, M2Sel;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(stall), .bubble(bubble), .M1Sel(M1Sel), .M2Sel(M2Sel), .stall_cnt(stall_cnt)
  );

  typedef struct {
    bit v; bit rw; bit mr; bit u1; bit u2;
    int rd; int rs1; int rs2;
  } instr_t;

  // hist[0] = instruction in EX, hist[1] = one older (MEM), hist[2] = two older (WB)
  instr_t hist[$];
  int     vec_cnt = 0;
  int     err_cnt = 0;
  int     model_stalls = 0;
  bit     last_stall = 0;
  instr_t cur;

  task automatic check_eq(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic instr_t nop_instr();
    instr_t n;
    n.v = 0; n.rw = 0; n.mr = 0; n.u1 = 0; n.u2 = 0; n.rd = 0; n.rs1 = 0; n.rs2 = 0;
    return n;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back(nop_instr());
    model_stalls = 0;
    last_stall = 0;
  endtask

  // newest older producer of a nonzero register wins; distance 1 -> MEM, 2 -> WB
  function automatic int exp_fwd(input int rs, input bit used);
    if (!used || rs == 0) return 0;
    for (int k = 1; k <= 2; k++)
      if (hist[k].v && hist[k].rw && hist[k].rd == rs) return (k == 1) ? 2 : 1;
    return 0;
  endfunction

  function automatic int exp_cnt();
`ifdef FWD_STALL_CNT_EN
    return model_stalls;
`else
    return 0;
`endif
  endfunction

  // Drives one cycle of ID/flush, checks outputs mid-cycle, advances the model.
  task automatic apply(input instr_t id, input bit fl);
    bit e_luh, e_stall, e_bubble;
    @(negedge clk);
    id_valid = id.v; id_rs1 = id.rs1[REG_AW-1:0]; id_rs2 = id.rs2[REG_AW-1:0];
    id_rs1_used = id.u1; id_rs2_used = id.u2; id_rd = id.rd[REG_AW-1:0];
    id_regwrite = id.rw; id_memread = id.mr; flush = fl;
    #1;
    e_luh = id.v && hist[0].v && hist[0].mr && hist[0].rd != 0 &&
            ((id.u1 && id.rs1 == hist[0].rd) || (id.u2 && id.rs2 == hist[0].rd));
    e_stall  = e_luh && !fl;
    e_bubble = e_stall || fl;
    check_eq("stall",     int'(stall),     int'(e_stall));
    check_eq("bubble",    int'(bubble),    int'(e_bubble));
    check_eq("M1Sel",     int'(M1Sel),     exp_fwd(hist[0].rs1, hist[0].u1));
    check_eq("M2Sel",     int'(M2Sel),     exp_fwd(hist[0].rs2, hist[0].u2));
    check_eq("stall_cnt", int'(stall_cnt), exp_cnt());
    if (e_stall) model_stalls++;
    last_stall = e_stall;
    hist.push_front(e_bubble ? nop_instr() : id);
    void'(hist.pop_back());
  endtask

  function automatic instr_t mk(input bit rw, input bit mr, input int rd,
                                input bit u1, input int rs1, input bit u2, input int rs2);
    instr_t n;
    n.v = 1; n.rw = rw; n.mr = mr; n.rd = rd; n.u1 = u1; n.rs1 = rs1; n.u2 = u2; n.rs2 = rs2;
    return n;
  endfunction

  task automatic drive_idle();
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = '0; id_regwrite = 0; id_memread = 0; flush = 0;
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_eq("rst_stall",  int'(stall),     0);
    check_eq("rst_bubble", int'(bubble),    0);
    check_eq("rst_M1Sel",  int'(M1Sel),     0);
    check_eq("rst_M2Sel",  int'(M2Sel),     0);
    check_eq("rst_cnt",    int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // add x5,x1,x2 ; sub x6,x5,x3
    apply(mk(1, 0, 5, 1, 1, 1, 2), 0);
    apply(mk(1, 0, 6, 1, 5, 1, 3), 0);
    apply(nop_instr(), 0);
    // add x5 ; nop ; or x7,x4,x5, then x5 rewritten with consumer right behind
    apply(mk(1, 0, 5, 1, 1, 1, 2), 0);
    apply(nop_instr(), 0);
    apply(mk(1, 0, 7, 1, 4, 1, 5), 0);
    apply(mk(1, 0, 5, 1, 1, 1, 2), 0);
    apply(mk(1, 0, 5, 1, 1, 1, 2), 0);
    apply(mk(1, 0, 7, 1, 4, 1, 5), 0);
    apply(nop_instr(), 0);
    // lw x8 ; add x9,x8,x8 (held during the stall)
    apply(mk(1, 1, 8, 1, 1, 0, 0), 0);
    apply(mk(1, 0, 9, 1, 8, 1, 8), 0);
    apply(mk(1, 0, 9, 1, 8, 1, 8), 0);
    apply(nop_instr(), 0);
    apply(nop_instr(), 0);
    // x0 writes never forwarded, lw x0 never stalls
    apply(mk(1, 0, 0, 1, 1, 0, 0), 0);
    apply(mk(1, 0, 2, 1, 0, 1, 0), 0);
    apply(mk(1, 1, 0, 1, 1, 0, 0), 0);
    apply(mk(1, 0, 3, 1, 0, 1, 0), 0);
    // load-use killed by flush
    apply(mk(1, 1, 8, 1, 1, 0, 0), 0);
    apply(mk(1, 0, 9, 1, 8, 1, 8), 1);
    apply(mk(1, 0, 4, 1, 1, 1, 2), 0);
    apply(nop_instr(), 0);

    // reset asserted while the stall is active
    apply(mk(1, 1, 8, 1, 1, 0, 0), 0);
    apply(mk(1, 0, 9, 1, 8, 1, 8), 0);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_stall",  int'(stall),     0);
    check_eq("arst_bubble", int'(bubble),    0);
    check_eq("arst_M1Sel",  int'(M1Sel),     0);
    check_eq("arst_M2Sel",  int'(M2Sel),     0);
    check_eq("arst_cnt",    int'(stall_cnt), 0);
    model_reset();
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 0, 10, 1, 11, 1, 12), 0);
    apply(mk(1, 0, 13, 1, 14, 1, 15), 0);

    // randomized traffic over a small register set to provoke many hits
    for (int i = 0; i < 3000; i++) begin
      instr_t n;
      bit fl;
      fl = ($urandom_range(0, 9) == 0);
      if (last_stall) begin
        n = cur;
      end else begin
        n.v   = ($urandom_range(0, 7) != 0);
        n.rw  = $urandom_range(0, 3) != 0;
        n.mr  = n.rw && ($urandom_range(0, 2) == 0);
        n.rd  = int'($urandom_range(0, 3));
        n.u1  = $urandom_range(0, 4) != 0;
        n.u2  = $urandom_range(0, 1) == 1;
        n.rs1 = int'($urandom_range(0, 3));
        n.rs2 = int'($urandom_range(0, 3));
      end
      cur = n;
      apply(n, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
